// File: rtl/exec_buf_stage.sv
// Execute-stage ALU of the 6-stage MIPS32 core (combinational) merged with
// the registered two-word inter-core buffer that feeds the multicore interconnect.
module exec_buf_stage #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic [WIDTH-1:0] ID_EX_rs_val,
   input  logic [WIDTH-1:0] ID_EX_rt_val,
   input  logic [WIDTH-1:0] ID_EX_ext_imm,
   input  logic [4:0]       ID_EX_shamt,
   input  logic [4:0]       ID_EX_rt,
   input  logic [4:0]       ID_EX_rd,
   input  logic [3:0]       ID_EX_ALUControl,
   input  logic             ID_EX_R,
   input  logic             ID_EX_JALControl,
   input  logic [WIDTH-1:0] ID_EX_PC4,
   output logic [WIDTH-1:0] EX_ALUResult,
   output logic [4:0]       EX_WriteRegister,
   input  logic             buf_write,
   input  logic             buf_stall,
   input  logic [WIDTH-1:0] buf_in_1,
   input  logic [WIDTH-1:0] buf_in_2,
   output logic [WIDTH-1:0] buf_out_1,
   output logic [WIDTH-1:0] buf_out_2,
   output logic             buf_flag
);

   localparam int unsigned REG_W   = 5;
   localparam int unsigned LUI_SH  = 16;
   localparam logic [REG_W-1:0] LINK_REG = REG_W'(31);

   localparam logic [3:0] OP_AND  = 4'd0;
   localparam logic [3:0] OP_OR   = 4'd1;
   localparam logic [3:0] OP_ADD  = 4'd2;
   localparam logic [3:0] OP_XOR  = 4'd3;
   localparam logic [3:0] OP_NOR  = 4'd4;
   localparam logic [3:0] OP_SLL  = 4'd5;
   localparam logic [3:0] OP_SRL  = 4'd6;
   localparam logic [3:0] OP_SRA  = 4'd7;
   localparam logic [3:0] OP_SUB  = 4'd8;
   localparam logic [3:0] OP_SLT  = 4'd9;
   localparam logic [3:0] OP_SLTU = 4'd10;
   localparam logic [3:0] OP_LUI  = 4'd11;
   localparam logic [3:0] OP_SLLV = 4'd12;
   localparam logic [3:0] OP_SRLV = 4'd13;
   localparam logic [3:0] OP_SRAV = 4'd14;
   localparam logic [3:0] OP_MUL  = 4'd15;

   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic [REG_W-1:0] var_sh;
   logic [WIDTH-1:0] alu_res;

   logic [WIDTH-1:0] buf_out_1_q, buf_out_1_d;
   logic [WIDTH-1:0] buf_out_2_q, buf_out_2_d;
   logic             buf_flag_q,  buf_flag_d;

   assign op_a   = ID_EX_rs_val;
   assign op_b   = ID_EX_R ? ID_EX_rt_val : ID_EX_ext_imm;
   assign var_sh = op_a[REG_W-1:0];

   // Low word of a product is the same for signed and unsigned operands.
   always_comb begin
      alu_res = '0;
      unique case (ID_EX_ALUControl)
         OP_AND:  alu_res = op_a & op_b;
         OP_OR:   alu_res = op_a | op_b;
         OP_ADD:  alu_res = op_a + op_b;
         OP_XOR:  alu_res = op_a ^ op_b;
         OP_NOR:  alu_res = ~(op_a | op_b);
         OP_SLL:  alu_res = op_b << ID_EX_shamt;
         OP_SRL:  alu_res = op_b >> ID_EX_shamt;
         OP_SRA:  alu_res = WIDTH'($signed(op_b) >>> ID_EX_shamt);
         OP_SUB:  alu_res = op_a - op_b;
         OP_SLT:  alu_res = WIDTH'($signed(op_a) < $signed(op_b));
         OP_SLTU: alu_res = WIDTH'(op_a < op_b);
         OP_LUI:  alu_res = op_b << LUI_SH;
         OP_SLLV: alu_res = op_b << var_sh;
         OP_SRLV: alu_res = op_b >> var_sh;
         OP_SRAV: alu_res = WIDTH'($signed(op_b) >>> var_sh);
         OP_MUL:  alu_res = op_a * op_b;
         default: alu_res = '0;
      endcase
   end

   // Jump-and-link overrides both the result and the destination.
   always_comb begin
      EX_ALUResult     = alu_res;
      EX_WriteRegister = ID_EX_R ? ID_EX_rd : ID_EX_rt;
      if (ID_EX_JALControl) begin
         EX_ALUResult     = ID_EX_PC4;
         EX_WriteRegister = LINK_REG;
      end
   end

   // Stall freezes everything; otherwise the flag mirrors this cycle's write.
   always_comb begin
      buf_out_1_d = buf_out_1_q;
      buf_out_2_d = buf_out_2_q;
      buf_flag_d  = buf_flag_q;
      if (!buf_stall) begin
         buf_flag_d = buf_write;
         if (buf_write) begin
            buf_out_1_d = buf_in_1;
            buf_out_2_d = buf_in_2;
         end
      end
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         buf_out_1_q <= '0;
         buf_out_2_q <= '0;
         buf_flag_q  <= 1'b0;
      end else begin
         buf_out_1_q <= buf_out_1_d;
         buf_out_2_q <= buf_out_2_d;
         buf_flag_q  <= buf_flag_d;
      end
   end

   assign buf_out_1 = buf_out_1_q;
   assign buf_out_2 = buf_out_2_q;
   assign buf_flag  = buf_flag_q;

endmodule

// File: tb/tb_exec_buf_stage.sv
// Directed bench for exec_buf_stage: ALU vector table plus hand-written
// buffer sequences covering capture, hold, stall and asynchronous reset.
module tb_exec_buf_stage;

   logic        clk;
   logic        rst_n;
   logic [31:0] rs_val, rt_val, ext_imm, pc4;
   logic [4:0]  shamt, rt_f, rd_f;
   logic [3:0]  alu_ctl;
   logic        r_type, jal;
   logic [31:0] alu_res;
   logic [4:0]  wr_reg;
   logic        buf_write, buf_stall;
   logic [31:0] buf_in_1, buf_in_2, buf_out_1, buf_out_2;
   logic        buf_flag;

   int checks = 0;
   int passes = 0;

   exec_buf_stage #(.WIDTH(32)) dut (
      .Clk              (clk),
      .Reset            (rst_n),
      .ID_EX_rs_val     (rs_val),
      .ID_EX_rt_val     (rt_val),
      .ID_EX_ext_imm    (ext_imm),
      .ID_EX_shamt      (shamt),
      .ID_EX_rt         (rt_f),
      .ID_EX_rd         (rd_f),
      .ID_EX_ALUControl (alu_ctl),
      .ID_EX_R          (r_type),
      .ID_EX_JALControl (jal),
      .ID_EX_PC4        (pc4),
      .EX_ALUResult     (alu_res),
      .EX_WriteRegister (wr_reg),
      .buf_write        (buf_write),
      .buf_stall        (buf_stall),
      .buf_in_1         (buf_in_1),
      .buf_in_2         (buf_in_2),
      .buf_out_1        (buf_out_1),
      .buf_out_2        (buf_out_2),
      .buf_flag         (buf_flag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [31:0] rs;
      logic [31:0] rt;
      logic [31:0] imm;
      logic [4:0]  sh;
      logic [4:0]  rtf;
      logic [4:0]  rdf;
      logic [3:0]  ctl;
      logic        r;
      logic        j;
      logic [31:0] pc;
      logic [31:0] exp_res;
      logic [4:0]  exp_wr;
   } vec_t;

   vec_t vecs[20];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp)
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      else
         passes++;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      //          name      rs            rt            imm           sh  rtf rdf ctl r  j  pc     exp_res       wr
      vecs[0]  = '{"add_r",  32'd5,        32'd7,        32'd0,        5'd0,  5'd3, 5'd9, 4'd2,  1, 0, 32'h0, 32'd12,       5'd9};
      vecs[1]  = '{"add_i",  32'd5,        32'd7,        32'hFFFFFFFF, 5'd0,  5'd3, 5'd9, 4'd2,  0, 0, 32'h0, 32'd4,        5'd3};
      vecs[2]  = '{"slt",    32'hFFFFFFFF, 32'd1,        32'd0,        5'd0,  5'd1, 5'd2, 4'd9,  1, 0, 32'h0, 32'd1,        5'd2};
      vecs[3]  = '{"sltu",   32'hFFFFFFFF, 32'd1,        32'd0,        5'd0,  5'd1, 5'd2, 4'd10, 1, 0, 32'h0, 32'd0,        5'd2};
      vecs[4]  = '{"sub",    32'd3,        32'd5,        32'd0,        5'd0,  5'd1, 5'd4, 4'd8,  1, 0, 32'h0, 32'hFFFFFFFE, 5'd4};
      vecs[5]  = '{"sll",    32'd0,        32'h80000000, 32'd0,        5'd4,  5'd1, 5'd5, 4'd5,  1, 0, 32'h0, 32'h00000000, 5'd5};
      vecs[6]  = '{"srl",    32'd0,        32'h80000000, 32'd0,        5'd4,  5'd1, 5'd5, 4'd6,  1, 0, 32'h0, 32'h08000000, 5'd5};
      vecs[7]  = '{"sra",    32'd0,        32'h80000000, 32'd0,        5'd4,  5'd1, 5'd5, 4'd7,  1, 0, 32'h0, 32'hF8000000, 5'd5};
      vecs[8]  = '{"srav",   32'h24,       32'h80000000, 32'd0,        5'd0,  5'd1, 5'd5, 4'd14, 1, 0, 32'h0, 32'hF8000000, 5'd5};
      vecs[9]  = '{"lui",    32'd0,        32'd0,        32'h1234,     5'd0,  5'd6, 5'd7, 4'd11, 0, 0, 32'h0, 32'h12340000, 5'd6};
      vecs[10] = '{"jal",    32'd1,        32'd2,        32'd3,        5'd0,  5'd6, 5'd7, 4'd2,  0, 1, 32'h40, 32'h40,       5'd31};
      vecs[11] = '{"jal_r",  32'd1,        32'd2,        32'd3,        5'd0,  5'd6, 5'd7, 4'd15, 1, 1, 32'h1000, 32'h1000,   5'd31};
      vecs[12] = '{"and",    32'hF0F0F0F0, 32'hFF00FF00, 32'd0,        5'd0,  5'd1, 5'd8, 4'd0,  1, 0, 32'h0, 32'hF000F000, 5'd8};
      vecs[13] = '{"or",     32'hF0F0F0F0, 32'hFF00FF00, 32'd0,        5'd0,  5'd1, 5'd8, 4'd1,  1, 0, 32'h0, 32'hFFF0FFF0, 5'd8};
      vecs[14] = '{"xor",    32'hF0F0F0F0, 32'hFF00FF00, 32'd0,        5'd0,  5'd1, 5'd8, 4'd3,  1, 0, 32'h0, 32'h0FF00FF0, 5'd8};
      vecs[15] = '{"nor",    32'hF0F0F0F0, 32'hFF00FF00, 32'd0,        5'd0,  5'd1, 5'd8, 4'd4,  1, 0, 32'h0, 32'h000F000F, 5'd8};
      vecs[16] = '{"mul",    32'hFFFFFFFF, 32'd7,        32'd0,        5'd0,  5'd1, 5'd8, 4'd15, 1, 0, 32'h0, 32'hFFFFFFF9, 5'd8};
      vecs[17] = '{"sllv",   32'hFFFFFFE1, 32'd3,        32'd0,        5'd9,  5'd1, 5'd8, 4'd12, 1, 0, 32'h0, 32'd6,        5'd8};
      vecs[18] = '{"srlv",   32'h21,       32'h80000000, 32'd0,        5'd9,  5'd1, 5'd8, 4'd13, 1, 0, 32'h0, 32'h40000000, 5'd8};
      vecs[19] = '{"sll31",  32'd0,        32'd1,        32'd0,        5'd31, 5'd1, 5'd8, 4'd5,  1, 0, 32'h0, 32'h80000000, 5'd8};

      rst_n = 1'b0;
      buf_write = 1'b0; buf_stall = 1'b0;
      buf_in_1 = 32'h0; buf_in_2 = 32'h0;
      rs_val = '0; rt_val = '0; ext_imm = '0; pc4 = '0;
      shamt = '0; rt_f = '0; rd_f = '0; alu_ctl = '0; r_type = 1'b0; jal = 1'b0;

      #12;
      chk("rst_out1", buf_out_1, 32'h0);
      chk("rst_out2", buf_out_2, 32'h0);
      chk("rst_flag", 32'(buf_flag), 32'h0);

      // ALU runs while reset is still asserted: it must not depend on it.
      foreach (vecs[i]) begin
         rs_val = vecs[i].rs; rt_val = vecs[i].rt; ext_imm = vecs[i].imm;
         shamt = vecs[i].sh; rt_f = vecs[i].rtf; rd_f = vecs[i].rdf;
         alu_ctl = vecs[i].ctl; r_type = vecs[i].r; jal = vecs[i].j; pc4 = vecs[i].pc;
         #1;
         chk({vecs[i].name, "_res"}, alu_res, vecs[i].exp_res);
         chk({vecs[i].name, "_wr"}, 32'(wr_reg), 32'(vecs[i].exp_wr));
      end

      @(negedge clk);
      rst_n = 1'b1;

      // Capture then idle.
      @(negedge clk);
      buf_write = 1'b1; buf_in_1 = 32'hAA; buf_in_2 = 32'hBB;
      tick();
      chk("cap_out1", buf_out_1, 32'hAA);
      chk("cap_out2", buf_out_2, 32'hBB);
      chk("cap_flag", 32'(buf_flag), 32'h1);
      buf_write = 1'b0; buf_in_1 = 32'h1; buf_in_2 = 32'h2;
      tick();
      chk("idle_out1", buf_out_1, 32'hAA);
      chk("idle_out2", buf_out_2, 32'hBB);
      chk("idle_flag", 32'(buf_flag), 32'h0);

      // Back-to-back writes keep the flag high.
      buf_write = 1'b1; buf_in_1 = 32'h11; buf_in_2 = 32'h22;
      tick();
      chk("b2b1_flag", 32'(buf_flag), 32'h1);
      buf_in_1 = 32'h33; buf_in_2 = 32'h44;
      tick();
      chk("b2b2_out1", buf_out_1, 32'h33);
      chk("b2b2_out2", buf_out_2, 32'h44);
      chk("b2b2_flag", 32'(buf_flag), 32'h1);

      // Stall with a pending write holds everything, including the flag.
      buf_stall = 1'b1; buf_in_1 = 32'h55; buf_in_2 = 32'h66;
      tick();
      chk("stall_out1", buf_out_1, 32'h33);
      chk("stall_out2", buf_out_2, 32'h44);
      chk("stall_flag", 32'(buf_flag), 32'h1);
      buf_stall = 1'b0; buf_write = 1'b0;
      tick();
      chk("unstall_flag", 32'(buf_flag), 32'h0);
      chk("unstall_out1", buf_out_1, 32'h33);

      // Asynchronous reset between edges.
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_out1", buf_out_1, 32'h0);
      chk("async_out2", buf_out_2, 32'h0);
      chk("async_flag", 32'(buf_flag), 32'h0);

      @(negedge clk);
      rst_n = 1'b1;
      buf_write = 1'b1; buf_in_1 = 32'hDEADBEEF; buf_in_2 = 32'h0BADF00D;
      tick();
      chk("post_rst_out1", buf_out_1, 32'hDEADBEEF);
      chk("post_rst_out2", buf_out_2, 32'h0BADF00D);
      chk("post_rst_flag", 32'(buf_flag), 32'h1);
      buf_write = 1'b0;
      tick();

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/exec_buf_stage.md
Name: exec_buf_stage

Overview:
- Execute-stage datapath of the 6-stage MIPS32 core, merged with the inter-core buffer register.
- Combinational ALU: computes the EX result and destination register from ID/EX pipeline fields.
- Registered 2-word buffer: captures rs/rt operand values from decode for the multicore interconnect and raises a flag.
- Sits between the ID/EX pipeline register and the EX/MEM pipeline register.

Parameters:
- WIDTH, 32, datapath width. Only 32 is supported.

Ports:
- Clk  in  1  rising-edge clock (buffer only).
- Reset  in  1  asynchronous, active-low reset.
- ID_EX_rs_val  in  32  operand A.
- ID_EX_rt_val  in  32  operand B when R-type.
- ID_EX_ext_imm  in  32  sign/zero-extended immediate, used as operand B when not R-type.
- ID_EX_shamt  in  5  fixed shift amount.
- ID_EX_rt  in  5  rt field.
- ID_EX_rd  in  5  rd field.
- ID_EX_ALUControl  in  4  operation select.
- ID_EX_R  in  1  R-type: selects rt_val as operand B and rd as destination.
- ID_EX_JALControl  in  1  jump-and-link.
- ID_EX_PC4  in  32  PC+4 of the instruction.
- EX_ALUResult  out  32  result (combinational).
- EX_WriteRegister  out  5  destination register (combinational).
- buf_write  in  1  capture request from decode.
- buf_stall  in  1  decode stall; buffer holds all state.
- buf_in_1  in  32  decode rs value.
- buf_in_2  in  32  decode rt value.
- buf_out_1  out  32  captured value 1.
- buf_out_2  out  32  captured value 2.
- buf_flag  out  1  capture-valid pulse.

Behaviour:
- Operand selection:
  - A = ID_EX_rs_val.
  - B = ID_EX_R ? ID_EX_rt_val : ID_EX_ext_imm.
- ALUControl encoding (results truncated to 32 bits):
  - 0 AND.
  - 1 OR.
  - 2 ADD (A+B, no overflow trap).
  - 3 XOR.
  - 4 NOR.
  - 5 SLL: B << shamt.
  - 6 SRL: B >> shamt, logical.
  - 7 SRA: B >>> shamt, arithmetic.
  - 8 SUB: A-B.
  - 9 SLT: signed A<B yields 1, else 0.
  - 10 SLTU: unsigned compare, same encoding.
  - 11 LUI: B << 16.
  - 12 SLLV: B << A[4:0].
  - 13 SRLV: B >> A[4:0].
  - 14 SRAV: B >>> A[4:0].
  - 15 MUL: low 32 bits of the signed product A*B.
- Shift count:
  - Ops 5/6/7 use the shamt port.
  - Ops 12/13/14 use only A[4:0]; A[31:5] is ignored.
- JAL:
  - When ID_EX_JALControl=1: EX_ALUResult = ID_EX_PC4 and EX_WriteRegister = 31, regardless of ALUControl and R.
  - There is no delay slot.
- Destination when JALControl=0: EX_WriteRegister = ID_EX_R ? ID_EX_rd : ID_EX_rt.
- The execute path is purely combinational (zero latency) and is unaffected by Clk and Reset.
- Buffer reset: when Reset=0, asynchronously clear buf_out_1=0, buf_out_2=0, buf_flag=0.
- Buffer operation on rising Clk with Reset=1, in priority order:
  - buf_stall=1: hold all three outputs, even if buf_write=1.
  - buf_write=1: buf_out_1 <= buf_in_1, buf_out_2 <= buf_in_2, buf_flag <= 1.
  - Otherwise: hold both data words, buf_flag <= 0.
- buf_flag is therefore high for exactly one non-stalled cycle per capture. Back-to-back writes keep it high.
- Reset asserted mid-operation clears the buffer immediately. The first write after reset release captures normally.

Test Plan:
- ADD with R=1, rs=5, rt=7, rd=9 -> result 12, WriteRegister 9. Same with R=0, ext_imm=0xFFFFFFFF -> result 4, WriteRegister = rt.
- SLT with A=0xFFFFFFFF, B=1 -> 1. SLTU with the same operands -> 0. SUB 3-5 -> 0xFFFFFFFE.
- Shifts with B=0x80000000, shamt=4:
  - SLL -> 0x00000000.
  - SRL -> 0x08000000.
  - SRA -> 0xF8000000.
  - SRAV with A=0x24 (uses A[4:0]=4) -> 0xF8000000.
  - LUI with B=0x1234 -> 0x12340000.
- JAL=1, PC4=0x40, ALUControl=2 -> result 0x40, WriteRegister 31.
- Buffer: write=1 with in 0xAA/0xBB -> next edge outputs 0xAA/0xBB, flag=1. Following idle cycle -> flag=0, data held.
- Buffer stall: stall=1 with write=1 and new inputs -> outputs and flag unchanged. Reset=0 between clock edges -> outputs 0 immediately.
